// File: rtl/router_sync_n.sv
// Latches the header destination address and steers the write enable, full flag and
// valid flags per channel; soft-resets a channel whose data stays unread TIMEOUT cycles.
// Decode is visible the cycle after detect_add. Stall timers are per channel and fully independent.
module router_sync_n #(
    parameter int NCH     = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30,
    parameter int TW      = $clog2(TIMEOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] din,
    input  logic              wr_en_reg,
    input  logic [NCH-1:0]    empty,
    input  logic [NCH-1:0]    full,
    input  logic [NCH-1:0]    read_enb,
    output logic [NCH-1:0]    write_enb,
    output logic              fifo_full,
    output logic [NCH-1:0]    valid_out,
    output logic [NCH-1:0]    soft_reset,
    output logic              addr_err
);

    localparam logic [ADDR_W:0] NCH_L  = (ADDR_W + 1)'(NCH);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

    logic [ADDR_W-1:0] addr_reg;
    logic [TW-1:0]     timer [NCH];
    logic [NCH-1:0]    stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg <= '0;
            addr_err <= 1'b0;
        end else if (detect_add) begin
            addr_reg <= din;
            addr_err <= ({1'b0, din} >= NCH_L);
        end
    end

    // Decode compares against every channel index so an out-of-range address selects nothing.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!addr_err && (addr_reg == ADDR_W'(i))) begin
                write_enb[i] = wr_en_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign valid_out = ~empty;
    assign stall     = valid_out & ~read_enb;

    // On expiry the timer restarts at zero, so a persisting stall pulses again TIMEOUT cycles later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                timer[i] <= '0;
            end
            soft_reset <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!stall[i]) begin
                    timer[i]      <= '0;
                    soft_reset[i] <= 1'b0;
                end else if (timer[i] == T_LAST) begin
                    timer[i]      <= '0;
                    soft_reset[i] <= 1'b1;
                end else begin
                    timer[i]      <= timer[i] + TW'(1);
                    soft_reset[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/router_sync_n.md
# router_sync_n

Parametrised address-decode and soft-reset controller for the router, generalising the fixed three-port sync block to NCH output channels. It latches the destination address at header time and steers the write enable to the selected output FIFO. It returns that FIFO's full flag, drives valid_out from each FIFO's empty flag, and soft-resets any channel whose data sits unread for TIMEOUT cycles. New over the previous generation: configurable channel count and timeout, an out-of-range address error flag, a timer that restarts on every read, and a single-cycle soft-reset pulse.

## Interface
- NCH, 3: number of output channels/FIFOs (2..8).
- ADDR_W, 2: width of din; must satisfy 2^ADDR_W >= NCH.
- TIMEOUT, 30: consecutive stalled cycles before soft reset (2..255).
- TW, $clog2(TIMEOUT): timer width (derived, do not override).

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- detect_add  in  1  header present on din this cycle; latch address.
- din  in  ADDR_W  destination address (low bits of header byte).
- wr_en_reg  in  1  FSM request to write current byte to selected FIFO.
- empty  in  NCH  per-FIFO empty flags.
- full  in  NCH  per-FIFO full flags.
- read_enb  in  NCH  per-channel read enable from output side.
- write_enb  out  NCH  one-hot FIFO write enable.
- fifo_full  out  1  full flag of currently addressed FIFO.
- valid_out  out  NCH  per-channel data-available (~empty).
- soft_reset  out  NCH  per-channel one-cycle FIFO clear pulse.
- addr_err  out  1  last latched address >= NCH.

## Operation
- addr_reg (ADDR_W, registered): loaded with din on any edge where detect_add=1; holds otherwise.
- addr_err (registered): on detect_add edge, set to (din >= NCH); holds otherwise.
- write_enb (combinational from registered state): bit addr_reg set iff wr_en_reg=1 and addr_err=0; otherwise all zero. Never more than one bit set.
- fifo_full (combinational): full[addr_reg] when addr_err=0, else 0.
- valid_out[i] = ~empty[i], purely combinational, independent of rst.
- Per channel i, timer_i (TW bits) and soft_reset[i] (registered):
  - stall_i = valid_out[i] & ~read_enb[i].
  - stall_i=0: timer_i <= 0, soft_reset[i] <= 0.
  - stall_i=1 and timer_i < TIMEOUT-1: timer_i <= timer_i+1, soft_reset[i] <= 0.
  - stall_i=1 and timer_i == TIMEOUT-1: soft_reset[i] <= 1, timer_i <= 0.
- soft_reset[i] is high for exactly one cycle per expiry. If the stall persists, the next pulse comes TIMEOUT cycles later.
- Channels are fully independent; multiple soft_reset bits may pulse in the same cycle.

## Timing
- Reset (rst=0, async): addr_reg=0, addr_err=0, all timers=0, soft_reset=0. write_enb then follows wr_en_reg toward channel 0; fifo_full=full[0].
- Address latency: detect_add at edge k gives the new write_enb/fifo_full decode from edge k onward (visible in cycle k+1).
- detect_add and wr_en_reg in the same cycle: write_enb uses the previous addr_reg.
- Soft-reset latency: stall held continuously across edges 1..TIMEOUT makes soft_reset rise after edge TIMEOUT and fall after edge TIMEOUT+1.
- read_enb or empty asserted on the terminal cycle (timer_i==TIMEOUT-1): no pulse, timer clears.
- Timer never exceeds TIMEOUT-1; no wrap to a nonzero value.
- rst asserted mid-count or during a pulse: timer and pulse clear immediately and asynchronously. Counting restarts from 0 after release.
- No combinational path from din or detect_add to any output.

## Test plan
- Decode: NCH=3, detect_add with din=2, then wr_en_reg=1 -> write_enb=3'b100 next cycle; full[2]=1 -> fifo_full=1; full[0]=1 alone -> fifo_full=0.
- Bad address: NCH=3, din=3 latched -> addr_err=1, write_enb=000 with wr_en_reg=1, fifo_full=0. Then din=1 latched -> addr_err=0, write_enb=010.
- Timeout: TIMEOUT=30, empty[1]=0, read_enb[1]=0 held -> soft_reset[1] high exactly one cycle after the 30th edge. soft_reset[0] and soft_reset[2] stay 0.
- Read restarts timer: stall 29 edges, read_enb[1]=1 for one cycle, then stall again -> no pulse until 30 further stalled edges.
- Simultaneous: channels 0 and 2 stalled from the same edge -> soft_reset=3'b101 in the same cycle; empty[0] rising at edge 29 -> only bit 2 pulses.
- Async reset: drop rst at timer=20 between edges -> soft_reset=0 immediately, addr_err=0. After release, a full 30 stalled edges are needed before a pulse.
